// File: rtl/display_pkg.sv
// display_pkg: shared state type, segment constants and hex glyph table
// for the multiplexed common-anode 7-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // Active-low glyphs, bit order g f e d c b a.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_scan_controller_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low 7-segment pattern (g..a).
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: blanked anode scan with frame-aligned req/ack data loading.
// Define SCAN_DIMMING_EN to add a brightness[3:0] input that PWMs each drive window.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digit_values,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          update_req,
`ifdef SCAN_DIMMING_EN
    input  logic [3:0]                    brightness,
`endif
    output logic                          update_ack,
    output logic [NUM_DIGITS-1:0]         anodes,
    output logic [6:0]                    segments,
    output logic                          dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_done
);

    localparam int CW        = $clog2(PRESCALE);
    localparam int DW        = $clog2(NUM_DIGITS);
    localparam int DRIVE_LEN = PRESCALE - BLANK_CYCLES;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           sel_q, sel_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d, anodes_q, anodes_d;
    logic [6:0]              segments_q, segments_d, seg_dec;
    logic                    dp_q, dp_d, ack_q, done_q;
    logic                    blank_end, drive_end, frame_end, capture, lit, dim_ok;

    assign blank_end = state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1);
    assign drive_end = state_q == DRIVE && cnt_q == CW'(DRIVE_LEN - 1);
    assign frame_end = drive_end && sel_q == DW'(NUM_DIGITS - 1);
    // The cycle after an ack ignores req so the requester has time to drop it.
    assign capture   = update_req && !ack_q && (frame_end || state_q == IDLE);
    assign shadow_d  = capture ? digit_values : shadow_q;
    assign sdp_d     = capture ? dp_in : sdp_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
            sel_d   = '0;
        end else if (blank_end) begin
            state_d = DRIVE;
        end else if (drive_end) begin
            state_d = BLANK;
            sel_d   = frame_end ? '0 : sel_q + DW'(1);
        end
        cnt_d = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + CW'(1);
    end

`ifdef SCAN_DIMMING_EN
    logic [3:0] bright_q, bright_d;
    assign bright_d = blank_end ? brightness : bright_q;
    assign dim_ok   = int'(cnt_d) * 16 < DRIVE_LEN * (int'(bright_d) + 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bright_q <= '0;
        else       bright_q <= bright_d;
    end
`else
    assign dim_ok = 1'b1;
`endif

    hex_to_7seg u_dec (
        .nibble_i(shadow_q[4*sel_q +: 4]),
        .seg_o   (seg_dec)
    );

    // Outputs are computed from next state so they switch with the state register.
    assign lit        = state_d == DRIVE && dim_ok;
    assign anodes_d   = lit ? ~(NUM_DIGITS'(1) << sel_q) : ANODES_OFF[NUM_DIGITS-1:0];
    assign segments_d = lit ? seg_dec : SEG_OFF;
    assign dp_d       = lit ? ~sdp_q[sel_q] : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            sdp_q      <= '0;
            anodes_q   <= ANODES_OFF[NUM_DIGITS-1:0];
            segments_q <= SEG_OFF;
            dp_q       <= 1'b1;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            sdp_q      <= sdp_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
            ack_q      <= capture;
            done_q     <= frame_end;
        end
    end

    assign update_ack = ack_q;
    assign anodes     = anodes_q;
    assign segments   = segments_q;
    assign dp_out     = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench; a frame-timeline model predicts every cycle.
module tb_display_scan_controller;

    localparam int ND = 4, PS = 20, BL = 4, DL = PS - BL, FRAME = ND * PS;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp, ack, done, scan;
        logic [1:0] sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, enable, update_req, update_ack, dp_out, frame_done;
    logic [15:0] digit_values;
    logic [3:0]  dp_in, anodes;
    logic [6:0]  segments;
    logic [1:0]  digit_sel;
`ifdef SCAN_DIMMING_EN
    logic [3:0]  brightness;
`endif

    int   tests = 0, fails = 0;
    exp_t q[$];
    exp_t me;

    // Model state: scanning flag, position in the 80-clock frame, shadow data.
    bit         m_scan, m_ack;
    int         m_t, m_b;
    logic [3:0] m_nib [ND];
    logic [3:0] m_dp;
    bit         drop;

    always #5 clk = ~clk;

    display_scan_controller #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .digit_values(digit_values), .dp_in(dp_in), .update_req(update_req),
`ifdef SCAN_DIMMING_EN
        .brightness(brightness),
`endif
        .update_ack(update_ack), .anodes(anodes), .segments(segments),
        .dp_out(dp_out), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    function automatic int b_now();
`ifdef SCAN_DIMMING_EN
        return int'(brightness);
`else
        return 15;
`endif
    endfunction

    task automatic model_reset();
        m_scan = 0; m_ack = 0; m_t = 0; m_b = 15; m_dp = '0;
        for (int i = 0; i < ND; i++) m_nib[i] = '0;
    endtask

    // Predict the outputs after the coming edge from the current inputs, then clock.
    task automatic step();
        exp_t e;
        int slot, off;
        bit last, cap;
        last = m_scan && m_t == FRAME - 1;
        cap  = update_req && !m_ack && (!m_scan || last);
        if (cap) begin
            for (int i = 0; i < ND; i++) m_nib[i] = digit_values[4*i +: 4];
            m_dp = dp_in;
        end
        m_ack = cap;
        if (!enable) m_scan = 0;
        else if (!m_scan) begin m_scan = 1; m_t = 0; end
        else m_t = (m_t + 1) % FRAME;
        slot = m_t / PS;
        off  = m_t % PS;
        if (m_scan && off == BL) m_b = b_now();
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ack: cap, done: last, scan: m_scan, sel: 2'(slot)};
        if (m_scan && off >= BL && (off - BL) * 16 < DL * (m_b + 1)) begin
            e.an  = ~(4'b0001 << slot);
            e.seg = GLYPH[m_nib[slot]];
            e.dp  = ~m_dp[slot];
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_dark(input string name);
        tests++;
        if (anodes !== 4'hF || segments !== 7'h7F || dp_out !== 1'b1 || update_ack !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL %s: anodes=%b seg=%h dp=%b ack=%b done=%b, expected anodes=1111 seg=7f dp=1 ack=0 done=0",
                     name, anodes, segments, dp_out, update_ack, frame_done);
        end
    endtask

    task automatic request(input logic [15:0] v, input logic [3:0] d);
        int n;
        digit_values = v; dp_in = d; update_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (update_ack !== 1'b1 && n < 200);
        update_req = 1'b0;
        tests++;
        if (update_ack !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: no update_ack within %0d clocks for data %h, expected ack=1", n, v);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            tests++;
            if (anodes !== me.an || segments !== me.seg || dp_out !== me.dp || update_ack !== me.ack ||
                frame_done !== me.done || (me.scan && digit_sel !== me.sel)) begin
                fails++;
                $display("FAIL cycle @%0t: got an=%b seg=%b dp=%b ack=%b done=%b sel=%0d, expected an=%b seg=%b dp=%b ack=%b done=%b sel=%0d",
                         $time, anodes, segments, dp_out, update_ack, frame_done, digit_sel,
                         me.an, me.seg, me.dp, me.ack, me.done, me.sel);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; update_req = 1'b0; digit_values = '0; dp_in = '0; drop = 0;
`ifdef SCAN_DIMMING_EN
        brightness = 4'hF;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_dark("reset_state");
        reset = 1'b0;
        request(16'h1234, 4'b0100);
        enable = 1'b1;
        repeat (200) step();
        for (int i = 0; i < 100 && !(m_scan && m_t / PS == 1); i++) step();
        request(16'hABCD, 4'b0001);
        repeat (100) step();
        for (int i = 0; i < 100 && !(m_scan && m_t % PS >= BL + 2); i++) step();
        enable = 1'b0;
        step();
        request(16'h5A5A, 4'b1000);
        repeat (3) step();
        enable = 1'b1;
        repeat (100) step();
        for (int i = 0; i < 100 && !(m_scan && m_t / PS == 2 && m_t % PS >= BL + 5); i++) step();
        reset = 1'b1;
        #1;
        check_dark("async_reset_mid_drive");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) step();
        request(16'h9F07, 4'b0110);
        repeat (100) step();
`ifdef SCAN_DIMMING_EN
        brightness = 4'd7;
        repeat (200) step();
        brightness = 4'd15;
        repeat (200) step();
`endif
        for (int i = 0; i < 3000; i++) begin
            if (drop) begin
                update_req = 1'b0; drop = 0;
            end else if (update_req && update_ack) begin
                if ($urandom_range(0, 1) == 1) drop = 1;
                else update_req = 1'b0;
            end else if (!update_req && $urandom_range(0, 39) == 0) begin
                digit_values = 16'($urandom); dp_in = 4'($urandom); update_req = 1'b1;
            end
            if (enable ? $urandom_range(0, 299) == 0 : $urandom_range(0, 7) == 0) enable = ~enable;
`ifdef SCAN_DIMMING_EN
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
`endif
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
